cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Downstream neighbour of the execute/writeback register stage.
- Takes the target/result channels it produces (alu, forwarder, mem) and buffers each in a per-source FIFO.
- Round-robin arbitrates the FIFOs onto a single registered common data bus (CDB) that feeds the ROB and reservation stations, one result per cycle.
- Back-pressures each execution unit with a per-source full flag.

Parameters:
- NSRC, 3, number of source channels (0=alu, 1=forwarder, 2=mem).
- DEPTH, 4, entries per source FIFO (power of two, >=2).
- TAG_W, 5, ROB tag width.
- DATA_W, 32, result width.
- TAG_INV, {TAG_W{1'b1}}, invalid-tag encoding; must equal `TAG_INVALID.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset: asserts immediately at 0, releases synchronously to clk.
- flush  input  1  synchronous pipeline flush (mispredict), active-high.
- src_tag  input  NSRC*TAG_W  per-source target; TAG_INV means no result this cycle.
- src_data  input  NSRC*DATA_W  per-source result.
- src_full  output  NSRC  per-source FIFO full; combinational from count.
- cdb_tag  output  TAG_W  broadcast target, registered; TAG_INV when idle.
- cdb_data  output  DATA_W  broadcast result, registered.
- overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset (rst=0):
  - all FIFO counts/pointers cleared; rr_ptr=0; overflow=0.
  - cdb_tag=TAG_INV; cdb_data=0; src_full=0.
- Push:
  - Source i pushes when src_tag[i]!=TAG_INV and flush=0.
  - Accepted if count_i<DEPTH, or count_i==DEPTH and source i is popped the same cycle.
  - Otherwise dropped and overflow<=1 (sticky until reset; flush does not clear it).
- src_full[i] = (count_i==DEPTH). Producers must hold off when it is high.
- Arbitration (each cycle flush=0):
  - Candidates = non-empty FIFOs, sampled before this cycle's pushes.
  - Grant the first candidate found scanning i = rr_ptr, rr_ptr+1, ... mod NSRC.
  - Granted head is popped; cdb_tag/cdb_data<=head at the edge; rr_ptr<=(grant+1) mod NSRC.
  - No candidate: cdb_tag<=TAG_INV, cdb_data holds, rr_ptr holds.
- Latency:
  - Result presented in cycle n is written at edge n, eligible in cycle n+1.
  - Earliest CDB appearance is cycle n+2.
  - No bypass path.
- Ordering: per-source FIFO order is preserved; no ordering guarantee across sources.
- Pointers: DEPTH is a power of two, so rd/wr pointers wrap naturally; count is $clog2(DEPTH)+1 bits.
- Same-cycle push and pop on one FIFO: count unchanged; the data written is the new entry.
- Flush=1:
  - all counts/pointers cleared; that cycle's inputs discarded.
  - cdb_tag<=TAG_INV; rr_ptr<=0.
  - Flush has priority over push/pop.
- Reset mid-operation: asynchronous clear regardless of FIFO contents; no partial broadcast.
- Throughput: 1 result/cycle total. Sustained input above 1/cycle fills FIFOs and must be back-pressured via src_full.

Optional Feature:
- CDB_PERF_EN: when defined, adds outputs:
  - perf_bcast  output  32  count of cycles with cdb_tag!=TAG_INV.
  - perf_stall  output  32  count of cycles with any src_full bit set.
  - Both reset to 0, cleared by rst only (not flush), wrap at 2^32.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan (NSRC=3, DEPTH=4, TAG_W=5, TAG_INV=5'h1f):
1. Reset release, all inputs 5'h1f for 5 cycles -> cdb_tag=5'h1f every cycle, src_full=0, overflow=0.
2. Single push alu tag=3, data=32'hdead_beef in cycle 1 -> cdb_tag=3, cdb_data=32'hdeadbeef in cycle 3 only; 5'h1f in cycle 4.
3. All three sources push in one cycle (tags 1,2,3), rr_ptr=0 -> CDB shows tags 1,2,3 on three consecutive cycles. Repeat with rr_ptr=2 -> order 3,1,2.
4. Push alu 5 times back-to-back with forwarder and mem also streaming -> src_full[0] asserts at count 4; the 5th alu push is dropped and overflow=1 and stays 1; the four accepted alu tags emerge in push order.
5. Fill all FIFOs to 2 entries, assert flush for one cycle -> next cycle cdb_tag=5'h1f, all counts 0, no stale tag ever broadcast; a push in the flush cycle is discarded.
6. rst pulled low mid-stream while cdb_tag=7 -> cdb_tag=5'h1f immediately (before the next edge), all FIFOs empty after release; with CDB_PERF_EN, perf_bcast=0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// -----------------------------------------------------------------------------
// Buffers the execute/writeback result channels (0=alu, 1=forwarder, 2=mem)
// in one FIFO per source and round-robin arbitrates the FIFO heads onto a
// single registered common data bus (CDB) feeding the ROB and reservation
// stations, one result per cycle.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset (synchronous release expected)
//   flush      synchronous pipeline flush, active-high; beats push and pop
//   src_tag    NSRC x TAG_W  per-source target tag, TAG_INV = no result
//   src_data   NSRC x DATA_W per-source result
//   src_full   NSRC          per-source FIFO full (count == DEPTH)
//   cdb_tag    TAG_W         registered broadcast tag, TAG_INV when idle
//   cdb_data   DATA_W        registered broadcast data, holds when idle
//   overflow   1             sticky: a push arrived at a full FIFO and was lost
//
// Handshake: a source presents a result by driving a tag other than TAG_INV
// for one cycle; there is no ready. The producer must look at src_full[i]
// and hold off while it is high. A push into a full FIFO is accepted only if
// that FIFO is popped in the same cycle; otherwise it is dropped and
// overflow is set.
//
// Optional feature (macro CDB_PERF_EN): adds perf_bcast (cycles with a valid
// broadcast on the CDB) and perf_stall (cycles with any src_full set).
// Both are 32-bit wrapping counters cleared by rst only.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int                NSRC    = 3,
    parameter int                DEPTH   = 4,
    parameter int                TAG_W   = 5,
    parameter int                DATA_W  = 32,
    parameter logic [TAG_W-1:0]  TAG_INV = {TAG_W{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NSRC*TAG_W-1:0]    src_tag,
    input  logic [NSRC*DATA_W-1:0]   src_data,
    output logic [NSRC-1:0]          src_full,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic                     overflow
`ifdef CDB_PERF_EN
    ,
    output logic [31:0]              perf_bcast,
    output logic [31:0]              perf_stall
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NSRC > 1) ? $clog2(NSRC) : 1;

    // FIFO storage (no reset needed: count gates every read)
    logic [TAG_W-1:0]  tag_mem_q  [NSRC][DEPTH];
    logic [TAG_W-1:0]  tag_mem_d  [NSRC][DEPTH];
    logic [DATA_W-1:0] data_mem_q [NSRC][DEPTH];
    logic [DATA_W-1:0] data_mem_d [NSRC][DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q [NSRC];
    logic [PTR_W-1:0]  rd_ptr_d [NSRC];
    logic [PTR_W-1:0]  wr_ptr_q [NSRC];
    logic [PTR_W-1:0]  wr_ptr_d [NSRC];
    logic [CNT_W-1:0]  count_q  [NSRC];
    logic [CNT_W-1:0]  count_d  [NSRC];

    logic [RR_W-1:0]   rr_q, rr_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic              overflow_q, overflow_d;

    logic              grant_vld;
    logic [RR_W-1:0]   grant_idx;
    logic [TAG_W-1:0]  head_tag;
    logic [DATA_W-1:0] head_data;
    logic [NSRC-1:0]   pop;
    logic [NSRC-1:0]   push_req;
    logic [NSRC-1:0]   push_ok;

    // -------------------------------------------------------------------------
    // Round-robin grant over non-empty FIFOs (counts before this cycle's pushes,
    // so a result is never bypassed onto the CDB in the cycle it arrives).
    // Each loop runs high-to-low so the last hit is the lowest index; the
    // second loop (indices at or after rr_q) overrides the wrapped first loop.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (count_q[i] != '0 && RR_W'(i) < rr_q) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(i);
            end
        end
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (count_q[i] != '0 && RR_W'(i) >= rr_q) begin
                grant_vld = 1'b1;
                grant_idx = RR_W'(i);
            end
        end

        head_tag  = TAG_INV;
        head_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant_idx == RR_W'(i)) begin
                head_tag  = tag_mem_q[i][rd_ptr_q[i]];
                head_data = data_mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO update, CDB register and round-robin pointer
    // -------------------------------------------------------------------------
    always_comb begin
        tag_mem_d  = tag_mem_q;
        data_mem_d = data_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        rr_d       = rr_q;
        cdb_tag_d  = TAG_INV;
        cdb_data_d = cdb_data_q;
        overflow_d = overflow_q;
        pop        = '0;
        push_req   = '0;
        push_ok    = '0;

        if (flush) begin
            for (int i = 0; i < NSRC; i++) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                count_d[i]  = '0;
            end
            rr_d = '0;
        end else begin
            if (grant_vld) begin
                cdb_tag_d  = head_tag;
                cdb_data_d = head_data;
                rr_d       = (grant_idx == RR_W'(NSRC - 1)) ? '0 : grant_idx + 1'b1;
            end
            for (int i = 0; i < NSRC; i++) begin
                pop[i]      = grant_vld && (grant_idx == RR_W'(i));
                push_req[i] = (src_tag[i*TAG_W +: TAG_W] != TAG_INV);
                // A full FIFO still accepts when its head leaves this cycle;
                // with wr_ptr == rd_ptr the slot written is the one vacated.
                push_ok[i]  = push_req[i] && ((count_q[i] != CNT_W'(DEPTH)) || pop[i]);
                if (push_req[i] && !push_ok[i]) begin
                    overflow_d = 1'b1;
                end
                if (push_ok[i]) begin
                    tag_mem_d[i][wr_ptr_q[i]]  = src_tag[i*TAG_W +: TAG_W];
                    data_mem_d[i][wr_ptr_q[i]] = src_data[i*DATA_W +: DATA_W];
                    wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
                end
                count_d[i] = count_q[i] + CNT_W'(push_ok[i]) - CNT_W'(pop[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_q       <= '0;
            cdb_tag_q  <= TAG_INV;
            cdb_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rr_q       <= rr_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_data_q <= cdb_data_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_mem_q  <= tag_mem_d;
        data_mem_q <= data_mem_d;
    end

    always_comb begin
        src_full = '0;
        for (int i = 0; i < NSRC; i++) begin
            src_full[i] = (count_q[i] == CNT_W'(DEPTH));
        end
    end

    assign cdb_tag  = cdb_tag_q;
    assign cdb_data = cdb_data_q;
    assign overflow = overflow_q;

`ifdef CDB_PERF_EN
    // Counters observe the registered outputs, so each edge accounts for the
    // cycle that just ended.
    logic [31:0] perf_bcast_q, perf_bcast_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_bcast_d = perf_bcast_q + {31'd0, (cdb_tag_q != TAG_INV)};
        perf_stall_d = perf_stall_q + {31'd0, (|src_full)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_bcast_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_bcast_q <= perf_bcast_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_bcast = perf_bcast_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Directed and random scenarios for cdb_arbiter (NSRC=3, DEPTH=4, TAG_W=5).
// Every cycle goes through step(): it drives the sources, predicts that
// edge's CDB value from a queue-based reference model into exp_q, then pops
// and compares after the edge. Scenario tasks add inline spot checks.
module tb_cdb_arbiter;

    localparam int         NSRC   = 3;
    localparam int         DEPTH  = 4;
    localparam int         TAG_W  = 5;
    localparam int         DATA_W = 32;
    localparam logic [4:0] INV    = 5'h1f;
    localparam int         EW     = TAG_W + DATA_W;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     flush = 1'b0;
    logic [NSRC*TAG_W-1:0]    src_tag = {NSRC{INV}};
    logic [NSRC*DATA_W-1:0]   src_data = '0;
    logic [NSRC-1:0]          src_full;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic                     overflow;
`ifdef CDB_PERF_EN
    logic [31:0]              perf_bcast;
    logic [31:0]              perf_stall;
`endif

    cdb_arbiter #(
        .NSRC(NSRC), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .TAG_INV(INV)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .src_tag(src_tag), .src_data(src_data),
        .src_full(src_full), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .overflow(overflow)
`ifdef CDB_PERF_EN
        , .perf_bcast(perf_bcast), .perf_stall(perf_stall)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard and reference model state
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mq[NSRC][$];
    int            m_rr = 0;
    logic          m_ovf = 1'b0;
    logic [31:0]   m_data = '0;

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) mq[i].delete();
        exp_q.delete();
        m_rr   = 0;
        m_ovf  = 1'b0;
        m_data = '0;
    endtask

    function automatic logic [NSRC*DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One clock cycle: drive, predict, wait for the edge, compare.
    task automatic step(input logic [NSRC*TAG_W-1:0] tags,
                        input logic [NSRC*DATA_W-1:0] datas,
                        input logic fl);
        logic [EW-1:0]   e;
        logic [EW-1:0]   got;
        logic [NSRC-1:0] exp_full;
        logic [4:0]      t;
        int              g;
        src_tag  = tags;
        src_data = datas;
        flush    = fl;
        if (fl) begin
            for (int i = 0; i < NSRC; i++) mq[i].delete();
            m_rr = 0;
            exp_q.push_back({INV, m_data});
        end else begin
            g = -1;
            for (int k = 0; k < NSRC; k++) begin
                if (g < 0 && mq[(m_rr + k) % NSRC].size() > 0) g = (m_rr + k) % NSRC;
            end
            if (g >= 0) begin
                e = mq[g].pop_front();
                m_data = e[DATA_W-1:0];
                m_rr = (g + 1) % NSRC;
                exp_q.push_back(e);
            end else begin
                exp_q.push_back({INV, m_data});
            end
            for (int i = 0; i < NSRC; i++) begin
                t = tags[i*TAG_W +: TAG_W];
                if (t != INV) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back({t, datas[i*DATA_W +: DATA_W]});
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        src_tag = {NSRC{INV}};
        flush   = 1'b0;
        e   = exp_q.pop_front();
        got = {cdb_tag, cdb_data};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL cdb_bus: got tag=%h data=%h, expected tag=%h data=%h",
                     cdb_tag, cdb_data, e[EW-1:DATA_W], e[DATA_W-1:0]);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow: got %b, expected %b", overflow, m_ovf);
        end
        for (int i = 0; i < NSRC; i++) exp_full[i] = (mq[i].size() == DEPTH);
        checks++;
        if (src_full !== exp_full) begin
            errors++;
            $display("FAIL src_full: got %b, expected %b", src_full, exp_full);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step({NSRC{INV}}, rnd_data(), 1'b0);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #10;
        checks++;
        if (cdb_tag !== INV || cdb_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_cdb: got tag=%h data=%h, expected tag=1f data=0", cdb_tag, cdb_data);
        end
        checks++;
        if (src_full !== 3'b000 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got full=%b ovf=%b, expected 000/0", src_full, overflow);
        end
        model_reset();
        @(negedge clk) rst = 1'b1;
        idle(5);
    endtask

    task automatic test_single();
        step({INV, INV, 5'd3}, {64'd0, 32'hdead_beef}, 1'b0);
        checks++;
        if (cdb_tag !== INV) begin
            errors++;
            $display("FAIL single_cyc2: got tag=%h, expected 1f", cdb_tag);
        end
        idle(1);
        checks++;
        if (cdb_tag !== 5'd3 || cdb_data !== 32'hdeadbeef) begin
            errors++;
            $display("FAIL single_cyc3: got tag=%h data=%h, expected 03/deadbeef", cdb_tag, cdb_data);
        end
        idle(1);
        checks++;
        if (cdb_tag !== INV) begin
            errors++;
            $display("FAIL single_cyc4: got tag=%h, expected 1f", cdb_tag);
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] seen[3];
        logic [4:0] want0[3];
        logic [4:0] want2[3];
        want0 = '{5'd1, 5'd2, 5'd3};
        want2 = '{5'd3, 5'd1, 5'd2};
        step({NSRC{INV}}, rnd_data(), 1'b1);   // flush -> rr_ptr = 0
        step({5'd3, 5'd2, 5'd1}, rnd_data(), 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            seen[k] = cdb_tag;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seen[k] !== want0[k]) begin
                errors++;
                $display("FAIL rr0_order[%0d]: got %h, expected %h", k, seen[k], want0[k]);
            end
        end
        // a lone forwarder grant moves rr_ptr to 2
        step({INV, 5'd9, INV}, rnd_data(), 1'b0);
        idle(2);
        step({5'd3, 5'd2, 5'd1}, rnd_data(), 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            seen[k] = cdb_tag;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (seen[k] !== want2[k]) begin
                errors++;
                $display("FAIL rr2_order[%0d]: got %h, expected %h", k, seen[k], want2[k]);
            end
        end
        idle(2);
    endtask

    task automatic test_overflow();
        logic       seen_full0;
        logic [4:0] tf;
        logic [4:0] tm;
        seen_full0 = 1'b0;
        step({NSRC{INV}}, rnd_data(), 1'b1);
        step({5'd20, 5'd10, INV}, rnd_data(), 1'b0);
        step({5'd21, 5'd11, INV}, rnd_data(), 1'b0);
        for (int k = 0; k < 8; k++) begin
            seen_full0 |= src_full[0];
            // forwarder and mem behave; alu ignores src_full
            tf = src_full[1] ? INV : 5'(12 + k);
            tm = src_full[2] ? INV : 5'(22 + k);
            step({tm, tf, 5'(k)}, rnd_data(), 1'b0);
        end
        checks++;
        if (seen_full0 !== 1'b1) begin
            errors++;
            $display("FAIL alu_full_seen: got %b, expected 1", seen_full0);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b, expected 1", overflow);
        end
        idle(16);
        step({NSRC{INV}}, rnd_data(), 1'b1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %b after flush, expected 1", overflow);
        end
    endtask

    task automatic test_flush();
        step({5'd4, 5'd5, 5'd6}, rnd_data(), 1'b0);
        step({5'd7, 5'd8, 5'd9}, rnd_data(), 1'b0);
        step({5'd10, 5'd11, 5'd12}, rnd_data(), 1'b1);
        checks++;
        if (cdb_tag !== INV || src_full !== 3'b000) begin
            errors++;
            $display("FAIL flush_clear: got tag=%h full=%b, expected 1f/000", cdb_tag, src_full);
        end
        for (int k = 0; k < 4; k++) begin
            idle(1);
            checks++;
            if (cdb_tag !== INV) begin
                errors++;
                $display("FAIL flush_stale[%0d]: got tag=%h, expected 1f", k, cdb_tag);
            end
        end
    endtask

    task automatic test_async_reset();
        step({5'd13, 5'd14, 5'd7}, rnd_data(), 1'b0);
        step({5'd15, 5'd16, 5'd17}, rnd_data(), 1'b0);
        idle(0);
        checks++;
        if (cdb_tag !== 5'd7) begin
            errors++;
            $display("FAIL pre_reset_tag: got %h, expected 07", cdb_tag);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cdb_tag !== INV || cdb_data !== 32'h0 || overflow !== 1'b0 || src_full !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got tag=%h data=%h ovf=%b full=%b, expected 1f/0/0/000",
                     cdb_tag, cdb_data, overflow, src_full);
        end
`ifdef CDB_PERF_EN
        checks++;
        if (perf_bcast !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d, expected 0", perf_bcast);
        end
`endif
        model_reset();
        @(negedge clk) rst = 1'b1;
        idle(4);
    endtask

    task automatic test_back_to_back();
        logic [NSRC*TAG_W-1:0] tags;
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (!src_full[i] && $urandom_range(0, 99) < 40)
                    tags[i*TAG_W +: TAG_W] = 5'($urandom_range(0, 30));
                else
                    tags[i*TAG_W +: TAG_W] = INV;
            end
            step(tags, rnd_data(), ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end
        idle(14);
        checks++;
        if (cdb_tag !== INV) begin
            errors++;
            $display("FAIL drain_idle: got tag=%h, expected 1f", cdb_tag);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
